// File: rtl/lsu_ecc_scrub_pkg.sv
// Shared types, sizing constants and the DCCM SECDED encoder used by the
// LSU ECC scrub queue.
package lsu_ecc_scrub_pkg;

    localparam int unsigned RV_DCCM_BITS    = 16;
    localparam int unsigned LSU_SCRUB_DEPTH = 2;

    typedef struct packed {
        logic                    valid;
        logic [RV_DCCM_BITS-1:0] addr;
        logic [31:0]             data;
    } scrub_entry_t;

    // Same parity masks as the DCCM write-path encoder; bit 6 is overall parity.
    function automatic logic [6:0] rvecc_encode(input logic [31:0] din);
        logic [5:0] p;
        p[0] = ^(din & 32'h56AA_AD5B);
        p[1] = ^(din & 32'h9B33_366D);
        p[2] = ^(din & 32'hE3C3_C78E);
        p[3] = ^(din & 32'h03FC_07F0);
        p[4] = ^(din & 32'h03FF_F800);
        p[5] = ^(din & 32'hFC00_0000);
        return {(^din) ^ (^p), p};
    endfunction

endpackage

// File: rtl/lsu_ecc_scrub.sv
// Queues single-bit ECC corrections seen in DC3 and writes the corrected,
// re-encoded words back into the DCCM through a shared write port.
module lsu_ecc_scrub
    import lsu_ecc_scrub_pkg::*;
#(
    parameter int unsigned DEPTH = LSU_SCRUB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_mode,
    input  logic                    dec_tlu_core_ecc_disable,
    input  logic                    single_ecc_error_lo_dc3,
    input  logic                    single_ecc_error_hi_dc3,
    input  logic                    lsu_double_ecc_error_dc3,
    input  logic [31:0]             sec_data_lo_dc3,
    input  logic [31:0]             sec_data_hi_dc3,
    input  logic [RV_DCCM_BITS-1:0] lsu_addr_dc3,
    input  logic [RV_DCCM_BITS-1:0] end_addr_dc3,
    input  logic                    stbuf_wr_en,
    input  logic [RV_DCCM_BITS-1:0] stbuf_wr_addr,
    output logic                    scrub_req,
    input  logic                    scrub_gnt,
    output logic                    scrub_wren,
    output logic [RV_DCCM_BITS-1:0] scrub_addr,
    output logic [38:0]             scrub_wr_data,
    output logic                    scrub_overflow,
    output logic [15:0]             scrub_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t                  state, state_n;
    scrub_entry_t            ent   [DEPTH];
    scrub_entry_t            ent_n [DEPTH];
    logic [PW-1:0]           head, head_n, tail, tail_n;
    logic [CW-1:0]           count, count_n, free;
    logic [RV_DCCM_BITS-1:0] addr_lo, addr_hi;
    logic                    cap_lo, cap_hi, lo_hit, hi_hit;
    logic                    pop, head_live, wren, drop;
    logic                    unused_ok;

    assign unused_ok = ^{scan_mode, lsu_addr_dc3[1:0], end_addr_dc3[1:0], stbuf_wr_addr[1:0]};

    always_comb begin
        addr_lo = {lsu_addr_dc3[RV_DCCM_BITS-1:2], 2'b00};
        addr_hi = {end_addr_dc3[RV_DCCM_BITS-1:2], 2'b00};
        cap_lo  = single_ecc_error_lo_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
        cap_hi  = single_ecc_error_hi_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
        lo_hit  = stbuf_wr_en && (addr_lo[RV_DCCM_BITS-1:2] == stbuf_wr_addr[RV_DCCM_BITS-1:2]);
        hi_hit  = stbuf_wr_en && (addr_hi[RV_DCCM_BITS-1:2] == stbuf_wr_addr[RV_DCCM_BITS-1:2]);

        // A store to the same word makes the corrected copy stale; kill it in place.
        ent_n = ent;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (stbuf_wr_en && (ent[i].addr[RV_DCCM_BITS-1:2] == stbuf_wr_addr[RV_DCCM_BITS-1:2]))
                ent_n[i].valid = 1'b0;
        end

        head_live = (count != '0) && ent_n[head].valid;
        wren      = (state == ST_REQ) && scrub_gnt && head_live && !rst;
        pop       = (count != '0) && (!ent[head].valid || ((state == ST_REQ) && scrub_gnt));

        head_n  = head;
        tail_n  = tail;
        count_n = count;
        drop    = 1'b0;
        if (pop) begin
            ent_n[head].valid = 1'b0;
            head_n  = head + PW'(1);
            count_n = count - CW'(1);
        end

        // Counting after the pop gives DEPTH - count + pop free slots.
        free = CW'(DEPTH) - count_n;
        if (cap_lo && !lo_hit) begin
            if (free != '0) begin
                ent_n[tail_n].valid = 1'b1;
                ent_n[tail_n].addr  = addr_lo;
                ent_n[tail_n].data  = sec_data_lo_dc3;
                tail_n  = tail_n + PW'(1);
                count_n = count_n + CW'(1);
                free    = free - CW'(1);
            end else begin
                drop = 1'b1;
            end
        end
        if (cap_hi && !hi_hit) begin
            if (free != '0) begin
                ent_n[tail_n].valid = 1'b1;
                ent_n[tail_n].addr  = addr_hi;
                ent_n[tail_n].data  = sec_data_hi_dc3;
                tail_n  = tail_n + PW'(1);
                count_n = count_n + CW'(1);
            end else begin
                drop = 1'b1;
            end
        end

        state_n = ST_IDLE;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_n[i].valid)
                state_n = ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            scrub_req      <= 1'b0;
            scrub_overflow <= 1'b0;
            scrub_count    <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            state          <= state_n;
            scrub_req      <= (state_n == ST_REQ);
            scrub_overflow <= drop;
            head           <= head_n;
            tail           <= tail_n;
            count          <= count_n;
            ent            <= ent_n;
            if (wren && (scrub_count != '1))
                scrub_count <= scrub_count + 16'd1;
        end
    end

    always_comb begin
        scrub_wren    = wren;
        scrub_addr    = ent[head].addr;
        scrub_wr_data = {rvecc_encode(ent[head].data), ent[head].data};
    end

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Directed self-checking bench for lsu_ecc_scrub.
module tb_lsu_ecc_scrub;
    import lsu_ecc_scrub_pkg::*;

    localparam int unsigned W = RV_DCCM_BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_mode, ecc_dis, sec_lo, sec_hi, ded;
    logic [31:0]   data_lo, data_hi;
    logic [W-1:0]  addr_lo, addr_hi, sb_addr;
    logic          sb_en, scrub_req, scrub_gnt, scrub_wren, scrub_overflow;
    logic [W-1:0]  scrub_addr;
    logic [38:0]   scrub_wr_data;
    logic [15:0]   scrub_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    lsu_ecc_scrub #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .scan_mode(scan_mode),
        .dec_tlu_core_ecc_disable(ecc_dis),
        .single_ecc_error_lo_dc3(sec_lo), .single_ecc_error_hi_dc3(sec_hi),
        .lsu_double_ecc_error_dc3(ded),
        .sec_data_lo_dc3(data_lo), .sec_data_hi_dc3(data_hi),
        .lsu_addr_dc3(addr_lo), .end_addr_dc3(addr_hi),
        .stbuf_wr_en(sb_en), .stbuf_wr_addr(sb_addr),
        .scrub_req(scrub_req), .scrub_gnt(scrub_gnt), .scrub_wren(scrub_wren),
        .scrub_addr(scrub_addr), .scrub_wr_data(scrub_wr_data),
        .scrub_overflow(scrub_overflow), .scrub_count(scrub_count)
    );

    always #5 clk = ~clk;

    // Classic Hamming layout: data in non-power-of-two positions 3..38.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [38:1] cw;
        logic [5:0]  p;
        int unsigned di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        p = '0;
        for (int k = 0; k < 6; k++)
            for (int pos = 1; pos <= 38; pos++)
                if (pos[k]) p[k] = p[k] ^ cw[pos];
        return {(^d) ^ (^p), p};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        sec_lo = 1'b0; sec_hi = 1'b0; ded = 1'b0; ecc_dis = 1'b0; sb_en = 1'b0;
        data_lo = '0; data_hi = '0; addr_lo = '0; addr_hi = '0; sb_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; scan_mode = 1'b0; scrub_gnt = 1'b0;
        idle_inputs();
        cyc(); cyc();
        rst = 1'b0; #1;
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", scrub_req); end
        n_cmp++; if (scrub_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren got=%b exp=0", scrub_wren); end
        n_cmp++; if (scrub_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", scrub_overflow); end
        n_cmp++; if (scrub_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", scrub_count); end
        n_cmp++; if (scrub_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", scrub_addr); end
        n_cmp++; if (scrub_wr_data !== 39'h0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", scrub_wr_data); end
    endtask

    task automatic test_single();
        scrub_gnt = 1'b1;
        sec_lo = 1'b1; data_lo = 32'hDEAD_BEEF; addr_lo = 16'h0100; #1;
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL single_req0 got=%b exp=0", scrub_req); end
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b1) begin n_err++; $display("FAIL single_req1 got=%b exp=1", scrub_req); end
        n_cmp++; if (scrub_wren !== 1'b1) begin n_err++; $display("FAIL single_wren got=%b exp=1", scrub_wren); end
        n_cmp++; if (scrub_addr !== 16'h0100) begin n_err++; $display("FAIL single_addr got=%h exp=0100", scrub_addr); end
        n_cmp++; if (scrub_wr_data !== {ref_ecc(32'hDEAD_BEEF), 32'hDEAD_BEEF}) begin n_err++;
            $display("FAIL single_wdata got=%h exp=%h", scrub_wr_data, {ref_ecc(32'hDEAD_BEEF), 32'hDEAD_BEEF}); end
        cyc(); #1;
        n_cmp++; if (scrub_wren !== 1'b0) begin n_err++; $display("FAIL single_wren_after got=%b exp=0", scrub_wren); end
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL single_req_after got=%b exp=0", scrub_req); end
        n_cmp++; if (scrub_count !== 16'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", scrub_count); end
    endtask

    task automatic test_pair();
        scrub_gnt = 1'b0;
        sec_lo = 1'b1; data_lo = 32'h1234_5678; addr_lo = 16'h0106;
        sec_hi = 1'b1; data_hi = 32'h8765_4321; addr_hi = 16'h0108;
        cyc(); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (scrub_req !== 1'b1 || scrub_wren !== 1'b0 || scrub_addr !== 16'h0104) begin n_err++;
                $display("FAIL pair_hold[%0d] got req=%b wren=%b addr=%h exp req=1 wren=0 addr=0104", i, scrub_req, scrub_wren, scrub_addr); end
            cyc();
        end
        scrub_gnt = 1'b1; #1;
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h0104 || scrub_wr_data !== {ref_ecc(32'h1234_5678), 32'h1234_5678}) begin n_err++;
            $display("FAIL pair_first got wren=%b addr=%h data=%h exp wren=1 addr=0104", scrub_wren, scrub_addr, scrub_wr_data); end
        cyc(); #1;
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h0108 || scrub_wr_data !== {ref_ecc(32'h8765_4321), 32'h8765_4321}) begin n_err++;
            $display("FAIL pair_second got wren=%b addr=%h data=%h exp wren=1 addr=0108", scrub_wren, scrub_addr, scrub_wr_data); end
        cyc(); #1;
        n_cmp++; if (scrub_req !== 1'b0 || scrub_count !== 16'd3) begin n_err++;
            $display("FAIL pair_end got req=%b count=%0d exp req=0 count=3", scrub_req, scrub_count); end
        scrub_gnt = 1'b0;
    endtask

    task automatic test_overflow();
        scrub_gnt = 1'b0;
        sec_lo = 1'b1; data_lo = 32'hC0C0_C0C0; addr_lo = 16'h0300;
        sec_hi = 1'b1; data_hi = 32'hD0D0_D0D0; addr_hi = 16'h0304;
        cyc(); idle_inputs();
        sec_lo = 1'b1; data_lo = 32'h0BAD_0BAD; addr_lo = 16'h0308; #1;
        n_cmp++; if (scrub_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre got=%b exp=0", scrub_overflow); end
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_single got=%b exp=1", scrub_overflow); end
        n_cmp++; if (scrub_addr !== 16'h0300) begin n_err++; $display("FAIL ovf_head got=%h exp=0300", scrub_addr); end
        sec_lo = 1'b1; addr_lo = 16'h0310; sec_hi = 1'b1; addr_hi = 16'h0314;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_double got=%b exp=1", scrub_overflow); end
        cyc();
        // Full queue with a pop in the same cycle still accepts one capture.
        scrub_gnt = 1'b1; sec_lo = 1'b1; data_lo = 32'hE0E0_E0E0; addr_lo = 16'h030C; #1;
        n_cmp++; if (scrub_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_one_pulse got=%b exp=0", scrub_overflow); end
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h0300 || scrub_wr_data !== {ref_ecc(32'hC0C0_C0C0), 32'hC0C0_C0C0}) begin n_err++;
            $display("FAIL ovf_drain0 got wren=%b addr=%h data=%h exp wren=1 addr=0300", scrub_wren, scrub_addr, scrub_wr_data); end
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pop_free got=%b exp=0", scrub_overflow); end
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h0304 || scrub_wr_data !== {ref_ecc(32'hD0D0_D0D0), 32'hD0D0_D0D0}) begin n_err++;
            $display("FAIL ovf_drain1 got wren=%b addr=%h data=%h exp wren=1 addr=0304", scrub_wren, scrub_addr, scrub_wr_data); end
        cyc(); #1;
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h030C || scrub_wr_data !== {ref_ecc(32'hE0E0_E0E0), 32'hE0E0_E0E0}) begin n_err++;
            $display("FAIL ovf_drain2 got wren=%b addr=%h data=%h exp wren=1 addr=030c", scrub_wren, scrub_addr, scrub_wr_data); end
        cyc(); scrub_gnt = 1'b0; #1;
        n_cmp++; if (scrub_req !== 1'b0 || scrub_count !== 16'd6) begin n_err++;
            $display("FAIL ovf_end got req=%b count=%0d exp req=0 count=6", scrub_req, scrub_count); end
    endtask

    task automatic test_hazard();
        scrub_gnt = 1'b0;
        sec_lo = 1'b1; data_lo = 32'hF00D_F00D; addr_lo = 16'h0200;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b1) begin n_err++; $display("FAIL haz_req got=%b exp=1", scrub_req); end
        sb_en = 1'b1; sb_addr = 16'h0202;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL haz_req_drop got=%b exp=0", scrub_req); end
        scrub_gnt = 1'b1; #1;
        n_cmp++; if (scrub_wren !== 1'b0) begin n_err++; $display("FAIL haz_wren got=%b exp=0", scrub_wren); end
        cyc(); #1;
        n_cmp++; if (scrub_wren !== 1'b0 || scrub_count !== 16'd6) begin n_err++;
            $display("FAIL haz_count got wren=%b count=%0d exp wren=0 count=6", scrub_wren, scrub_count); end
        scrub_gnt = 1'b0;
        // Grant and store hit the head in the same cycle.
        sec_lo = 1'b1; data_lo = 32'h0000_0210; addr_lo = 16'h0210;
        cyc(); idle_inputs();
        scrub_gnt = 1'b1; sb_en = 1'b1; sb_addr = 16'h0210; #1;
        n_cmp++; if (scrub_wren !== 1'b0) begin n_err++; $display("FAIL haz_gnt_wren got=%b exp=0", scrub_wren); end
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b0 || scrub_count !== 16'd6) begin n_err++;
            $display("FAIL haz_gnt_end got req=%b count=%0d exp req=0 count=6", scrub_req, scrub_count); end
        scrub_gnt = 1'b0;
        // Capture that collides with a same-cycle store is simply not queued.
        sec_lo = 1'b1; data_lo = 32'h0000_0220; addr_lo = 16'h0220; sb_en = 1'b1; sb_addr = 16'h0221;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b0 || scrub_overflow !== 1'b0) begin n_err++;
            $display("FAIL haz_cap got req=%b ovf=%b exp req=0 ovf=0", scrub_req, scrub_overflow); end
    endtask

    task automatic test_suppress();
        scrub_gnt = 1'b0;
        sec_lo = 1'b1; ded = 1'b1; addr_lo = 16'h0230; data_lo = 32'h1;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL sup_ded got=%b exp=0", scrub_req); end
        sec_hi = 1'b1; ecc_dis = 1'b1; addr_hi = 16'h0234; data_hi = 32'h2;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL sup_dis got=%b exp=0", scrub_req); end
        sec_lo = 1'b1; addr_lo = 16'h0250; data_lo = 32'hA5A5_5A5A;
        cyc(); idle_inputs();
        ecc_dis = 1'b1; scrub_gnt = 1'b1; #1;
        n_cmp++; if (scrub_wren !== 1'b1 || scrub_addr !== 16'h0250) begin n_err++;
            $display("FAIL sup_drain got wren=%b addr=%h exp wren=1 addr=0250", scrub_wren, scrub_addr); end
        cyc(); ecc_dis = 1'b0; scrub_gnt = 1'b0; #1;
        n_cmp++; if (scrub_count !== 16'd7) begin n_err++; $display("FAIL sup_count got=%0d exp=7", scrub_count); end
    endtask

    task automatic test_reset_mid();
        scrub_gnt = 1'b0;
        sec_lo = 1'b1; addr_lo = 16'h0260; data_lo = 32'h7777_1111;
        cyc(); idle_inputs(); #1;
        n_cmp++; if (scrub_req !== 1'b1) begin n_err++; $display("FAIL rmid_req got=%b exp=1", scrub_req); end
        rst = 1'b1; scrub_gnt = 1'b1; #1;
        n_cmp++; if (scrub_wren !== 1'b0) begin n_err++; $display("FAIL rmid_wren got=%b exp=0", scrub_wren); end
        cyc(); rst = 1'b0; #1;
        n_cmp++; if (scrub_req !== 1'b0 || scrub_wren !== 1'b0 || scrub_overflow !== 1'b0) begin n_err++;
            $display("FAIL rmid_ctl got req=%b wren=%b ovf=%b exp 0 0 0", scrub_req, scrub_wren, scrub_overflow); end
        n_cmp++; if (scrub_count !== 16'd0 || scrub_addr !== 16'h0 || scrub_wr_data !== 39'h0) begin n_err++;
            $display("FAIL rmid_data got count=%0d addr=%h data=%h exp all 0", scrub_count, scrub_addr, scrub_wr_data); end
        cyc(); #1;
        n_cmp++; if (scrub_wren !== 1'b0 || scrub_req !== 1'b0) begin n_err++;
            $display("FAIL rmid_after got req=%b wren=%b exp 0 0", scrub_req, scrub_wren); end
        scrub_gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_overflow();
        test_hazard();
        test_suppress();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
